// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetch sequencer for a byte-wide instruction memory. Reads four bytes per
//   instruction (big-endian, lowest address = most significant byte), builds
//   the 32-bit word and hands it to decode with a valid/ready handshake.
//   Handles redirects, stalls and misaligned or out-of-range fetch PCs.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   stall          freezes fetch progress while high
//   redirect       load redirect_addr as the new PC (beats stall)
//   redirect_addr  redirect target
//   mem_addr       byte address to instruction memory (pc + byte count)
//   mem_rd         memory read strobe
//   mem_data       byte returned combinationally for mem_addr
//   instr          assembled instruction
//   instr_pc       PC of instr
//   instr_valid    instr/instr_pc hold a complete instruction
//   instr_ready    decode accepts the instruction
//   addr_fault     fetch halted on a bad address
//   pc             current fetch PC
module instr_fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        addr_fault,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {StFetch, StValid, StFault} state_e;

    state_e      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        instr_valid_q;
    logic        addr_fault_q;
    // Low for the edge that first samples reset high, so the first read of
    // RESET_PC happens in the cycle after that edge.
    logic        run_q;

    logic [31:0] pc_plus4;

    // Word-aligned and the whole word lies inside memory. 33-bit compare so a
    // PC near the top of the address space cannot wrap into looking legal.
    function automatic logic legal_pc(input logic [31:0] a);
        legal_pc = (a[1:0] == 2'b00) && (({1'b0, a} + 33'd3) < 33'(MEM_BYTES));
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    assign mem_addr = pc_q + {30'd0, byte_cnt_q};
    assign mem_rd   = reset && run_q && (state_q == StFetch) && !stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StFetch;
            byte_cnt_q    <= 2'd0;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect) begin
                // A handshake in this same cycle still completes: decode takes
                // the word at this edge, only the PC+4 step is overridden.
                instr_valid_q <= 1'b0;
                byte_cnt_q    <= 2'd0;
                pc_q          <= redirect_addr;
                if (legal_pc(redirect_addr)) begin
                    state_q      <= StFetch;
                    addr_fault_q <= 1'b0;
                end else begin
                    state_q      <= StFault;
                    addr_fault_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StFetch: begin
                        if (run_q && !stall) begin
                            unique case (byte_cnt_q)
                                2'd0: instr_q[31:24] <= mem_data;
                                2'd1: instr_q[23:16] <= mem_data;
                                2'd2: instr_q[15:8]  <= mem_data;
                                2'd3: instr_q[7:0]   <= mem_data;
                                default: ;
                            endcase
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                instr_pc_q    <= pc_q;
                                instr_valid_q <= 1'b1;
                                state_q       <= StValid;
                            end
                        end
                    end
                    StValid: begin
                        // Stall deliberately does not gate the handshake.
                        if (instr_ready) begin
                            instr_valid_q <= 1'b0;
                            pc_q          <= pc_plus4;
                            byte_cnt_q    <= 2'd0;
                            if (legal_pc(pc_plus4)) begin
                                state_q <= StFetch;
                            end else begin
                                state_q      <= StFault;
                                addr_fault_q <= 1'b1;
                            end
                        end
                    end
                    StFault: begin
                        // Parked until a legal redirect or reset.
                    end
                    default: begin
                        state_q <= StFault;
                    end
                endcase
            end
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign addr_fault  = addr_fault_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        addr_fault;
    logic [31:0] pc;

    logic [7:0]  mem [0:127];

    int checks;
    int failures;

    instr_fetch_ctrl #(
        .MEM_BYTES(128),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .addr_fault   (addr_fault),
        .pc           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 8'h00;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'd0; instr_ready = 1'b0;
        step(); step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (addr_fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", addr_fault); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h want 0", pc); end
        checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_rd: got %b want 0", mem_rd); end
        reset = 1'b1;
        #1;
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_rd_release: got %b want 0", mem_rd); end
        step();
        checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL rst_rd_first: got %b want 1", mem_rd); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr_first: got %h want 0", mem_addr); end
    endtask

    task automatic test_sequential();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_addr !== 32'(i) || mem_rd !== 1'b1) begin
                failures++; $display("FAIL seq_addr0: got %h/%b want %h/1", mem_addr, mem_rd, i);
            end
            step();
        end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid0: got %b want 1", instr_valid); end
        checks++; if (instr !== 32'h8C01_0004) begin failures++; $display("FAIL seq_instr0: got %h want 8c010004", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL seq_pc0: got %h want 0", instr_pc); end
        checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL seq_rd_valid: got %b want 0", mem_rd); end
        step();
        checks++; if (instr_valid !== 1'b0 || pc !== 32'd4) begin
            failures++; $display("FAIL seq_accept: got %b/%h want 0/4", instr_valid, pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_addr !== 32'(4 + i)) begin
                failures++; $display("FAIL seq_addr1: got %h want %h", mem_addr, 4 + i);
            end
            step();
        end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid1: got %b want 1", instr_valid); end
        checks++; if (instr !== 32'h0022_1820) begin failures++; $display("FAIL seq_instr1: got %h want 00221820", instr); end
        checks++; if (instr_pc !== 32'd4) begin failures++; $display("FAIL seq_pc1: got %h want 4", instr_pc); end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure_stall();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h0022_1820 || mem_rd !== 1'b0) begin
                failures++; $display("FAIL bp_hold: got %b/%h/%b want 1/00221820/0", instr_valid, instr, mem_rd);
            end
        end
        instr_ready = 1'b1;
        step();
        checks++; if (instr_valid !== 1'b0 || pc !== 32'd8) begin
            failures++; $display("FAIL bp_accept: got %b/%h want 0/8", instr_valid, pc);
        end
        step(); step();
        stall = 1'b1;
        #1;
        checks++; if (mem_addr !== 32'd10 || mem_rd !== 1'b0) begin
            failures++; $display("FAIL stall_addr: got %h/%b want 0a/0", mem_addr, mem_rd);
        end
        step(); step();
        checks++; if (mem_addr !== 32'd10 || pc !== 32'd8 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL stall_hold: got %h/%h/%b want 0a/8/0", mem_addr, pc, instr_valid);
        end
        stall = 1'b0;
        #1;
        checks++; if (mem_addr !== 32'd10 || mem_rd !== 1'b1) begin
            failures++; $display("FAIL stall_resume: got %h/%b want 0a/1", mem_addr, mem_rd);
        end
        step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_early: got %b want 0", instr_valid); end
        instr_ready = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hCAFE_BABE || instr_pc !== 32'd8) begin
            failures++; $display("FAIL stall_word: got %b/%h/%h want 1/cafebabe/8", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_redirect();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (pc !== 32'd12) begin failures++; $display("FAIL rd_pc12: got %h want 0c", pc); end
        step();
        checks++; if (mem_addr !== 32'd13) begin failures++; $display("FAIL rd_partial: got %h want 0d", mem_addr); end
        redirect = 1'b1; redirect_addr = 32'h40;
        step();
        redirect = 1'b0;
        checks++; if (pc !== 32'h40 || instr_valid !== 1'b0 || mem_addr !== 32'h40) begin
            failures++; $display("FAIL rd_target: got %h/%b/%h want 40/0/40", pc, instr_valid, mem_addr);
        end
        step(); step(); step();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rd_early: got %b want 0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF || instr_pc !== 32'h40) begin
            failures++; $display("FAIL rd_word: got %b/%h/%h want 1/deadbeef/40", instr_valid, instr, instr_pc);
        end
        // Handshake and redirect at the same edge.
        instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h0;
        step();
        instr_ready = 1'b0; redirect = 1'b0;
        checks++; if (pc !== 32'h0 || instr_valid !== 1'b0 || mem_addr !== 32'h0) begin
            failures++; $display("FAIL rd_hs_pc: got %h/%b/%h want 0/0/0", pc, instr_valid, mem_addr);
        end
        step(); step(); step(); step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C01_0004 || instr_pc !== 32'h0) begin
            failures++; $display("FAIL rd_hs_word: got %b/%h/%h want 1/8c010004/0", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_faults();
        redirect = 1'b1; redirect_addr = 32'h42;
        step();
        redirect = 1'b0;
        checks++; if (addr_fault !== 1'b1 || mem_rd !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h42) begin
            failures++; $display("FAIL flt_misalign: got %b/%b/%b/%h want 1/0/0/42", addr_fault, mem_rd, instr_valid, pc);
        end
        step();
        checks++; if (addr_fault !== 1'b1 || pc !== 32'h42) begin
            failures++; $display("FAIL flt_stay: got %b/%h want 1/42", addr_fault, pc);
        end
        redirect = 1'b1; redirect_addr = 32'h80;
        step();
        redirect = 1'b0;
        checks++; if (addr_fault !== 1'b1 || pc !== 32'h80) begin
            failures++; $display("FAIL flt_range: got %b/%h want 1/80", addr_fault, pc);
        end
        redirect = 1'b1; redirect_addr = 32'h7C;
        step();
        redirect = 1'b0;
        checks++; if (addr_fault !== 1'b0 || pc !== 32'h7C || mem_addr !== 32'h7C || mem_rd !== 1'b1) begin
            failures++; $display("FAIL flt_last_start: got %b/%h/%h/%b want 0/7c/7c/1", addr_fault, pc, mem_addr, mem_rd);
        end
        step(); step(); step(); step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1122_3344 || instr_pc !== 32'h7C) begin
            failures++; $display("FAIL flt_last_word: got %b/%h/%h want 1/11223344/7c", instr_valid, instr, instr_pc);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (addr_fault !== 1'b1 || pc !== 32'h80 || instr_valid !== 1'b0 || mem_rd !== 1'b0) begin
            failures++; $display("FAIL flt_end: got %b/%h/%b/%b want 1/80/0/0", addr_fault, pc, instr_valid, mem_rd);
        end
        redirect = 1'b1; redirect_addr = 32'h0;
        step();
        redirect = 1'b0;
        checks++; if (addr_fault !== 1'b0 || mem_addr !== 32'h0 || mem_rd !== 1'b1) begin
            failures++; $display("FAIL flt_clear: got %b/%h/%b want 0/0/1", addr_fault, mem_addr, mem_rd);
        end
        step(); step(); step(); step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C01_0004) begin
            failures++; $display("FAIL flt_resume: got %b/%h want 1/8c010004", instr_valid, instr);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while in VALID.
        reset = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b0 || addr_fault !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || mem_rd !== 1'b0) begin
            failures++; $display("FAIL rstv: got %b/%b/%h/%h/%b want 0/0/0/0/0", instr_valid, addr_fault, pc, instr, mem_rd);
        end
        reset = 1'b1;
        step();
        redirect = 1'b1; redirect_addr = 32'h42;
        step();
        redirect = 1'b0;
        checks++; if (addr_fault !== 1'b1) begin failures++; $display("FAIL rstf_pre: got %b want 1", addr_fault); end
        // Reset while in FAULT.
        reset = 1'b0;
        step();
        checks++; if (addr_fault !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0 || instr_pc !== 32'h0) begin
            failures++; $display("FAIL rstf: got %b/%h/%b/%h want 0/0/0/0", addr_fault, pc, instr_valid, instr_pc);
        end
        reset = 1'b1;
        step();
        checks++; if (mem_addr !== 32'h0 || mem_rd !== 1'b1) begin
            failures++; $display("FAIL rst_refetch: got %h/%b want 0/1", mem_addr, mem_rd);
        end
        step(); step(); step(); step();
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C01_0004 || instr_pc !== 32'h0) begin
            failures++; $display("FAIL rst_reword: got %b/%h/%h want 1/8c010004/0", instr_valid, instr, instr_pc);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[0]   = 8'h8C; mem[1]   = 8'h01; mem[2]   = 8'h00; mem[3]   = 8'h04;
        mem[4]   = 8'h00; mem[5]   = 8'h22; mem[6]   = 8'h18; mem[7]   = 8'h20;
        mem[8]   = 8'hCA; mem[9]   = 8'hFE; mem[10]  = 8'hBA; mem[11]  = 8'hBE;
        mem[12]  = 8'h01; mem[13]  = 8'h02; mem[14]  = 8'h03; mem[15]  = 8'h04;
        mem[64]  = 8'hDE; mem[65]  = 8'hAD; mem[66]  = 8'hBE; mem[67]  = 8'hEF;
        mem[124] = 8'h11; mem[125] = 8'h22; mem[126] = 8'h33; mem[127] = 8'h44;

        test_reset();
        test_sequential();
        test_backpressure_stall();
        test_redirect();
        test_faults();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
